// File: rtl/sigma_seq_divider.sv
// Sequential 2W/W non-restoring divider with signed mode, divide-by-zero/overflow flags and start/done handshake.
// Optional macro SIGMA_DIV_RADIX4_EN retires two quotient bits per ITER cycle; undefined builds the radix-2 datapath.
module sigma_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  // Sigma numbers bit 0 as the MSB; here that bit is [2*WIDTH-1] / [WIDTH-1], the value is unchanged.
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               divide_by_zero,
  output logic               overflow
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG_MAG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SIGMA_DIV_RADIX4_EN
  localparam logic [CNT_W-1:0] STEP = CNT_W'(2);
`else
  localparam logic [CNT_W-1:0] STEP = CNT_W'(1);
`endif

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic                 r_sgn_mode;
  logic                 r_qsign;
  logic                 r_rsign;
  logic [WIDTH:0]       r_pr;
  logic [WIDTH-1:0]     r_pq;
  logic [WIDTH-1:0]     r_d;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_q_res;
  logic [WIDTH-1:0]     r_r_res;

  logic                 w_dvd_neg;
  logic                 w_dvs_neg;
  logic [2*WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]     w_dvs_mag;
  logic [2*WIDTH:0]     w_pair;
  logic [2*WIDTH:0]     w_next;
  logic [WIDTH-1:0]     w_rem_mag;
  logic                 w_sgn_ovf;

  // One non-restoring step on {partial remainder (W+1), quotient (W)}. The shifted remainder
  // needs W+2 bits; the result is back in [-d, d) so its top two bits agree.
  function automatic logic [2*WIDTH:0] nr_step(input logic [2*WIDTH:0] pair,
                                               input logic [WIDTH-1:0] d);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] res;
    shifted = pair[2*WIDTH:WIDTH-1];
    if (shifted[WIDTH+1]) res = shifted + {2'b00, d};
    else                  res = shifted - {2'b00, d};
    return {res[WIDTH:0], pair[WIDTH-2:0], ~res[WIDTH+1]};
  endfunction

  assign w_dvd_neg = r_sgn_mode & r_dvd[2*WIDTH-1];
  assign w_dvs_neg = r_sgn_mode & r_dvs[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -r_dvd : r_dvd;
  assign w_dvs_mag = w_dvs_neg ? -r_dvs : r_dvs;

  assign w_pair = {r_pr, r_pq};
`ifdef SIGMA_DIV_RADIX4_EN
  assign w_next = nr_step(nr_step(w_pair, r_d), r_d);
`else
  assign w_next = nr_step(w_pair, r_d);
`endif

  // Final remainder lies in [0, d), so the correction fits in WIDTH bits.
  assign w_rem_mag = r_pr[WIDTH] ? (r_pr[WIDTH-1:0] + r_d) : r_pr[WIDTH-1:0];
  assign w_sgn_ovf = r_sgn_mode & (r_qsign ? (r_pq > MIN_NEG_MAG) : r_pq[WIDTH-1]);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_dvd          <= '0;
      r_dvs          <= '0;
      r_sgn_mode     <= 1'b0;
      r_qsign        <= 1'b0;
      r_rsign        <= 1'b0;
      r_pr           <= '0;
      r_pq           <= '0;
      r_d            <= '0;
      r_cnt          <= '0;
      r_q_res        <= '0;
      r_r_res        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      quotient       <= '0;
      remainder      <= '0;
      divide_by_zero <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd          <= dividend;
            r_dvs          <= divisor;
            r_sgn_mode     <= signed_mode;
            divide_by_zero <= 1'b0;
            overflow       <= 1'b0;
            busy           <= 1'b1;
            r_state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_qsign <= w_dvd_neg ^ w_dvs_neg;
          r_rsign <= w_dvd_neg;
          r_d     <= w_dvs_mag;
          r_pr    <= {1'b0, w_dvd_mag[2*WIDTH-1:WIDTH]};
          r_pq    <= w_dvd_mag[WIDTH-1:0];
          r_cnt   <= CNT_W'(WIDTH);
          if (w_dvs_mag == '0) begin
            divide_by_zero <= 1'b1;
            r_state        <= S_DONE;
          end else if (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag) begin
            overflow <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          {r_pr, r_pq} <= w_next;
          r_cnt        <= r_cnt - STEP;
          if (r_cnt == STEP) r_state <= S_FIX;
        end
        S_FIX: begin
          overflow <= w_sgn_ovf;
          r_q_res  <= r_qsign ? -r_pq : r_pq;
          r_r_res  <= r_rsign ? -w_rem_mag : w_rem_mag;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (!divide_by_zero && !overflow) begin
            quotient  <= r_q_res;
            remainder <= r_r_res;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_seq_divider.sv
// Directed bench for sigma_seq_divider (WIDTH=32): results, flags, latency, handshake and reset abort.
module tb_sigma_seq_divider;

`ifdef SIGMA_DIV_RADIX4_EN
  localparam int NORM_LAT = 19;
`else
  localparam int NORM_LAT = 35;
`endif
  localparam int FLAG_LAT = 2;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        signed_mode;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divide_by_zero;
  logic        overflow;

  int n_checks;
  int n_fail;

  sigma_seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .signed_mode    (signed_mode),
    .dividend       (dividend),
    .divisor        (divisor),
    .busy           (busy),
    .done           (done),
    .quotient       (quotient),
    .remainder      (remainder),
    .divide_by_zero (divide_by_zero),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulses start for one edge, then watches 60 edges: first done cycle, done count, busy after edge 1 and at done.
  task automatic run_div(input logic sm, input logic [63:0] dvd, input logic [31:0] dvs,
                         output int lat, output int ndone, output logic busy1, output logic busy_d);
    @(negedge clock);
    signed_mode = sm;
    dividend    = dvd;
    divisor     = dvs;
    start       = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = -1; ndone = 0; busy1 = 1'b0; busy_d = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) busy1 = busy;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat    = c;
          busy_d = busy;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({busy, done, divide_by_zero, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {busy, done, divide_by_zero, overflow});
    end
    n_checks++;
    if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 00000000", quotient); end
    n_checks++;
    if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h expected 00000000", remainder); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    int lat, nd; logic b1, bd;
    run_div(1'b0, 64'h00000000_00000064, 32'd7, lat, nd, b1, bd);
    n_checks++; if (lat != NORM_LAT) begin n_fail++; $display("FAIL basic_lat: got %0d expected %0d", lat, NORM_LAT); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL basic_ndone: got %0d expected 1", nd); end
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy1: got %b expected 1", b1); end
    n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 0", bd); end
    n_checks++; if (quotient !== 32'h0000000E) begin n_fail++; $display("FAIL basic_q: got %h expected 0000000e", quotient); end
    n_checks++; if (remainder !== 32'h00000002) begin n_fail++; $display("FAIL basic_r: got %h expected 00000002", remainder); end
    n_checks++; if ({divide_by_zero, overflow} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b expected 00", {divide_by_zero, overflow}); end
  endtask

  task automatic test_divide_by_zero();
    int lat, nd; logic b1, bd;
    run_div(1'b0, 64'h00000000_00000064, 32'd0, lat, nd, b1, bd);
    n_checks++; if (lat != FLAG_LAT) begin n_fail++; $display("FAIL dbz_lat: got %0d expected %0d", lat, FLAG_LAT); end
    n_checks++; if ({divide_by_zero, overflow} !== 2'b10) begin n_fail++; $display("FAIL dbz_flags: got %b expected 10", {divide_by_zero, overflow}); end
    n_checks++; if (quotient !== 32'h0000000E) begin n_fail++; $display("FAIL dbz_q_held: got %h expected 0000000e", quotient); end
    n_checks++; if (remainder !== 32'h00000002) begin n_fail++; $display("FAIL dbz_r_held: got %h expected 00000002", remainder); end
    // Zero divisor and high word >= divisor together: only divide_by_zero is reported.
    run_div(1'b0, 64'h00000001_00000000, 32'd0, lat, nd, b1, bd);
    n_checks++; if ({divide_by_zero, overflow} !== 2'b10) begin n_fail++; $display("FAIL dbz_prio_flags: got %b expected 10", {divide_by_zero, overflow}); end
    n_checks++; if (lat != FLAG_LAT) begin n_fail++; $display("FAIL dbz_prio_lat: got %0d expected %0d", lat, FLAG_LAT); end
  endtask

  task automatic test_signed();
    int lat, nd; logic b1, bd;
    run_div(1'b1, 64'hFFFFFFFF_FFFFFF9C, 32'd7, lat, nd, b1, bd);
    n_checks++; if (lat != NORM_LAT) begin n_fail++; $display("FAIL sgn_pos_lat: got %0d expected %0d", lat, NORM_LAT); end
    n_checks++; if ({divide_by_zero, overflow} !== 2'b00) begin n_fail++; $display("FAIL sgn_flags_cleared: got %b expected 00", {divide_by_zero, overflow}); end
    n_checks++; if (quotient !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL sgn_pos_q: got %h expected fffffff2", quotient); end
    n_checks++; if (remainder !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sgn_pos_r: got %h expected fffffffe", remainder); end
    run_div(1'b1, 64'hFFFFFFFF_FFFFFF9C, 32'hFFFFFFF9, lat, nd, b1, bd);
    n_checks++; if (quotient !== 32'h0000000E) begin n_fail++; $display("FAIL sgn_neg_q: got %h expected 0000000e", quotient); end
    n_checks++; if (remainder !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sgn_neg_r: got %h expected fffffffe", remainder); end
  endtask

  task automatic test_overflow();
    int lat, nd; logic b1, bd;
    run_div(1'b0, 64'h00000001_00000000, 32'd1, lat, nd, b1, bd);
    n_checks++; if (lat != FLAG_LAT) begin n_fail++; $display("FAIL ovf_u_lat: got %0d expected %0d", lat, FLAG_LAT); end
    n_checks++; if ({divide_by_zero, overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_u_flags: got %b expected 01", {divide_by_zero, overflow}); end
    n_checks++; if (quotient !== 32'h0000000E) begin n_fail++; $display("FAIL ovf_u_q_held: got %h expected 0000000e", quotient); end
    // -2^31 / -1: passes the early check, overflows at FIX.
    run_div(1'b1, 64'hFFFFFFFF_80000000, 32'hFFFFFFFF, lat, nd, b1, bd);
    n_checks++; if (lat != NORM_LAT) begin n_fail++; $display("FAIL ovf_s_lat: got %0d expected %0d", lat, NORM_LAT); end
    n_checks++; if ({divide_by_zero, overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_s_flags: got %b expected 01", {divide_by_zero, overflow}); end
    n_checks++; if (remainder !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL ovf_s_r_held: got %h expected fffffffe", remainder); end
    // -2^31 / 1: negative result exactly at the limit, no overflow.
    run_div(1'b1, 64'hFFFFFFFF_80000000, 32'd1, lat, nd, b1, bd);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_lim_flag: got %b expected 0", overflow); end
    n_checks++; if (quotient !== 32'h80000000) begin n_fail++; $display("FAIL ovf_lim_q: got %h expected 80000000", quotient); end
    n_checks++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL ovf_lim_r: got %h expected 00000000", remainder); end
  endtask

  task automatic test_unsigned_max();
    int lat, nd; logic b1, bd;
    run_div(1'b0, 64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, lat, nd, b1, bd);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL umax_flag: got %b expected 0", overflow); end
    n_checks++; if (quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL umax_q: got %h expected ffffffff", quotient); end
    n_checks++; if (remainder !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL umax_r: got %h expected fffffffe", remainder); end
  endtask

  task automatic test_busy_ignore();
    int lat, nd;
    lat = -1; nd = 0;
    @(negedge clock);
    signed_mode = 1'b0; dividend = 64'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock);
      #1 start = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) lat = c;
      end
      if (c == 9) begin
        start = 1'b1; dividend = 64'd1000; divisor = 32'd3;
      end
    end
    n_checks++; if (lat != NORM_LAT) begin n_fail++; $display("FAIL busy_ign_lat: got %0d expected %0d", lat, NORM_LAT); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL busy_ign_ndone: got %0d expected 1", nd); end
    n_checks++; if (quotient !== 32'h0000000E) begin n_fail++; $display("FAIL busy_ign_q: got %h expected 0000000e", quotient); end
    n_checks++; if (remainder !== 32'h00000002) begin n_fail++; $display("FAIL busy_ign_r: got %h expected 00000002", remainder); end
  endtask

  task automatic test_reset_abort();
    int lat, nd; logic b1, bd;
    @(negedge clock);
    signed_mode = 1'b1; dividend = 64'hFFFFFFFF_FFFFFF9C; divisor = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, divide_by_zero, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_ctl: got %b expected 0000", {busy, done, divide_by_zero, overflow});
    end
    n_checks++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL abort_q: got %h expected 00000000", quotient); end
    n_checks++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL abort_r: got %h expected 00000000", remainder); end
    @(negedge clock);
    reset_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (done) nd++;
    end
    n_checks++; if (nd != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
    run_div(1'b0, 64'h00000000_00000064, 32'd7, lat, nd, b1, bd);
    n_checks++; if (lat != NORM_LAT) begin n_fail++; $display("FAIL abort_fresh_lat: got %0d expected %0d", lat, NORM_LAT); end
    n_checks++; if (quotient !== 32'h0000000E) begin n_fail++; $display("FAIL abort_fresh_q: got %h expected 0000000e", quotient); end
    n_checks++; if (remainder !== 32'h00000002) begin n_fail++; $display("FAIL abort_fresh_r: got %h expected 00000002", remainder); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_unsigned_basic();
    test_divide_by_zero();
    test_signed();
    test_overflow();
    test_unsigned_max();
    test_busy_ignore();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
